sram_req_ctrl: RTL

- Initiator side of the single-port sram interface: converts pipeline-side burst requests into per-cycle sram strobes.
- Accepts one request at a time on a valid/ready handshake.
  - Read burst: drives `len+1` consecutive read beats and returns each word on a registered valid/ready response stream.
  - Write burst: fills `len+1` consecutive words with a constant (memset/clear).
- Sits between a pipeline stage or DMA-style client and one sram instance.

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/sram_req_ctrl_if.sv | 34 +++
 rtl/sram_rsp_slot.sv | 30 +++
 rtl/sram_req_ctrl.sv | 64 ++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default widths for the sram request controller
package sram_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int LEN_W = 4;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: request/response handshake plus sram strobe bundle
interface sram_req_ctrl_if import sram_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LEN_WIDTH = LEN_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] sram_address;
  logic [DATA_WIDTH-1:0] sram_wd;
  logic                  sram_banksel;
  logic                  sram_read;
  logic                  sram_write;
  logic [DATA_WIDTH-1:0] sram_dataout;
  modport master (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, sram_dataout,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy,
           sram_address, sram_wd, sram_banksel, sram_read, sram_write
  );
  modport slave (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, sram_dataout,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy,
           sram_address, sram_wd, sram_banksel, sram_read, sram_write
  );
endinterface

// File: rtl/sram_rsp_slot.sv
// sram_rsp_slot: single-entry valid/ready output register
module sram_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  last_in,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ready,
  output logic                  valid,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);
  assign free = !valid || ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= last_in;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: turns read/fill burst requests into per-cycle sram strobes
module sram_req_ctrl import sram_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LEN_WIDTH = LEN_W
) (
  input logic            clk,
  input logic            rst,
  sram_req_ctrl_if.master bus
);
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  beat, len_r;
  logic [DATA_WIDTH-1:0] fill;
  logic                  free, accept, issue, wr, last;
  assign accept = state == IDLE && bus.req_valid;
  assign issue  = state == RD && free;
  assign wr     = state == WR;
  assign last   = beat == len_r;
  always_comb begin
    state_nx         = state;
    bus.req_ready    = state == IDLE;
    bus.busy         = state != IDLE;
    bus.sram_read    = issue;
    bus.sram_write   = wr;
    bus.sram_banksel = issue || wr;
    bus.sram_address = (issue || wr) ? cur_addr : '0;
    bus.sram_wd      = wr ? fill : '0;
    if (accept) state_nx = bus.req_write ? WR : RD;
    else if ((issue || wr) && last) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      beat     <= '0;
      len_r    <= '0;
      fill     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cur_addr <= bus.req_addr;
        len_r    <= bus.req_len;
        fill     <= bus.req_wdata;
        beat     <= '0;
      end else if (issue || wr) begin
        cur_addr <= cur_addr + 1'b1;
        beat     <= beat + 1'b1;
      end
    end
  end
  sram_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (issue),
    .last_in (last),
    .din     (bus.sram_dataout),
    .ready   (bus.rsp_ready),
    .valid   (bus.rsp_valid),
    .last    (bus.rsp_last),
    .data    (bus.rsp_data),
    .free    (free)
  );
endmodule
